// File: rtl/graphite_cmd_encoder_pkg.sv
// Shared opcodes, primitive codes and sequence constants for the graphite
// command stream encoder.
package graphite_cmd_encoder_pkg;

    localparam int OP_POS  = 12;
    localparam int OP_SIZE = 4;

    localparam logic [3:0] OP_SET_X0        = 4'h0;
    localparam logic [3:0] OP_SET_Y0        = 4'h1;
    localparam logic [3:0] OP_SET_X1        = 4'h2;
    localparam logic [3:0] OP_SET_Y1        = 4'h3;
    localparam logic [3:0] OP_SET_X2        = 4'h4;
    localparam logic [3:0] OP_SET_Y2        = 4'h5;
    localparam logic [3:0] OP_SET_U0        = 4'h6;
    localparam logic [3:0] OP_SET_V0        = 4'h7;
    localparam logic [3:0] OP_SET_U1        = 4'h8;
    localparam logic [3:0] OP_SET_V1        = 4'h9;
    localparam logic [3:0] OP_SET_U2        = 4'hA;
    localparam logic [3:0] OP_SET_V2        = 4'hB;
    localparam logic [3:0] OP_SET_COLOR     = 4'hC;
    localparam logic [3:0] OP_CLEAR         = 4'hD;
    localparam logic [3:0] OP_DRAW_LINE     = 4'hE;
    localparam logic [3:0] OP_DRAW_TRIANGLE = 4'hF;

    localparam int LEN_TRIANGLE = 8;
    localparam int LEN_LINE     = 6;
    localparam int LEN_CLEAR    = 2;

    typedef enum logic [1:0] {
        PRIM_CLEAR    = 2'd0,
        PRIM_LINE     = 2'd1,
        PRIM_TRIANGLE = 2'd2
    } prim_t;

    // F_NONE selects the constant-zero payload of DRAW/CLEAR words
    typedef enum logic [2:0] {
        F_X0, F_Y0, F_X1, F_Y1, F_X2, F_Y2, F_COLOR, F_NONE
    } fsel_t;

    typedef enum logic [1:0] {
        S_IDLE, S_SEND, S_DONE
    } state_t;

endpackage

// File: rtl/graphite_cmd_encoder_seq.sv
// Maps (primitive, word index) to the opcode, payload field and
// last-word flag of that position in the command sequence.
module graphite_cmd_seq
    import graphite_cmd_encoder_pkg::*;
(
    input  logic [1:0] prim,
    input  logic [2:0] idx,
    output logic [3:0] opcode,
    output fsel_t      fsel,
    output logic       last,
    output logic       hit
);

    always_comb begin
        opcode = OP_CLEAR;
        fsel   = F_NONE;
        last   = 1'b0;
        hit    = 1'b0;
        unique case (prim)
            PRIM_TRIANGLE: begin
                hit  = 1'b1;
                last = (idx == 3'(LEN_TRIANGLE - 1));
                case (idx)
                    3'd6: begin
                        opcode = OP_SET_COLOR;
                        fsel   = F_COLOR;
                    end
                    3'd7: opcode = OP_DRAW_TRIANGLE;
                    default: begin
                        opcode = OP_SET_X0 + 4'(idx);
                        fsel   = fsel_t'(idx);
                    end
                endcase
            end
            PRIM_LINE: begin
                hit  = (idx < 3'(LEN_LINE));
                last = (idx == 3'(LEN_LINE - 1));
                case (idx)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        opcode = OP_SET_X0 + 4'(idx);
                        fsel   = fsel_t'(idx);
                    end
                    3'd4: begin
                        opcode = OP_SET_COLOR;
                        fsel   = F_COLOR;
                    end
                    3'd5: opcode = OP_DRAW_LINE;
                    default: ;
                endcase
            end
            PRIM_CLEAR: begin
                hit  = (idx < 3'(LEN_CLEAR));
                last = (idx == 3'(LEN_CLEAR - 1));
                if (idx == 3'd0) begin
                    opcode = OP_SET_COLOR;
                    fsel   = F_COLOR;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/graphite_cmd_encoder.sv
// Primitive-to-command-word encoder with an AXI-stream master output.
// Optional GRAPHITE_CMD_DEDUP_EN skips SET_* words already known downstream.
module graphite_cmd_encoder
    import graphite_cmd_encoder_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_prim_i,
    input  logic [11:0]                 req_x0_i,
    input  logic [11:0]                 req_y0_i,
    input  logic [11:0]                 req_x1_i,
    input  logic [11:0]                 req_y1_i,
    input  logic [11:0]                 req_x2_i,
    input  logic [11:0]                 req_y2_i,
    input  logic [11:0]                 req_color_i,
    input  logic                        invalidate_i,
    output logic                        cmd_axis_tvalid_o,
    input  logic                        cmd_axis_tready_i,
    output logic [CMD_STREAM_WIDTH-1:0] cmd_axis_tdata_o,
    output logic                        busy_o,
    output logic                        done_o
);

    if (CMD_STREAM_WIDTH != 16) begin : g_bad_width
        $error("graphite_cmd_encoder supports only 16-bit words");
    end

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  prim_q, src_prim;
    logic [11:0] fld_q [8];
    logic [11:0] fld_in [8];
    logic [11:0] src_fld [8];
    logic        tvalid_q, tvalid_d;
    logic [15:0] tdata_q, tdata_d;
    logic [15:0] word_nxt;

    logic [3:0]  op_k [8];
    fsel_t       fs_k [8];
    logic [7:0]  last_k, hit_k, skip_k, cand;
    logic [3:0]  start;
    logic [2:0]  nxt;
    logic        found, xfer, load;

    always_comb begin
        fld_in[0] = req_x0_i;
        fld_in[1] = req_y0_i;
        fld_in[2] = req_x1_i;
        fld_in[3] = req_y1_i;
        fld_in[4] = req_x2_i;
        fld_in[5] = req_y2_i;
        fld_in[6] = req_color_i;
        fld_in[7] = 12'h000;
    end

    // In IDLE the first word is formed straight from the request inputs
    always_comb begin
        src_prim = prim_q;
        src_fld  = fld_q;
        if (state_q == S_IDLE) begin
            src_prim = req_prim_i;
            src_fld  = fld_in;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_seq
        graphite_cmd_seq u_seq (
            .prim   (src_prim),
            .idx    (3'(k)),
            .opcode (op_k[k]),
            .fsel   (fs_k[k]),
            .last   (last_k[k]),
            .hit    (hit_k[k])
        );
    end

    assign xfer = tvalid_q && cmd_axis_tready_i;

`ifdef GRAPHITE_CMD_DEDUP_EN
    logic [11:0] shd_q [8];
    logic [7:0]  shd_vld_q;
    logic        inv_now;

    assign inv_now = (state_q == S_IDLE) && invalidate_i;

    always_comb begin
        skip_k = '0;
        for (int k = 0; k < 8; k++) begin
            if (fs_k[k] != F_NONE && shd_vld_q[fs_k[k]] && !inv_now &&
                shd_q[fs_k[k]] == src_fld[fs_k[k]])
                skip_k[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            shd_vld_q <= '0;
        end else begin
            if (inv_now)
                shd_vld_q <= '0;
            if (xfer && fs_k[idx_q] != F_NONE) begin
                shd_q[fs_k[idx_q]]     <= tdata_q[11:0];
                shd_vld_q[fs_k[idx_q]] <= 1'b1;
            end
        end
    end
`else
    logic unused_invalidate;
    assign unused_invalidate = invalidate_i;
    assign skip_k = '0;
`endif

    assign start = (state_q == S_IDLE) ? 4'd0 : {1'b0, idx_q} + 4'd1;

    // Lowest eligible index at or after start wins
    always_comb begin
        found = 1'b0;
        nxt   = 3'd0;
        for (int k = 0; k < 8; k++)
            cand[k] = hit_k[k] && !skip_k[k] && (4'(k) >= start);
        for (int k = 7; k >= 0; k--) begin
            if (cand[k]) begin
                found = 1'b1;
                nxt   = 3'(k);
            end
        end
    end

    assign word_nxt = {op_k[nxt], src_fld[fs_k[nxt]]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        load     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    load = 1'b1;
                    if (found) begin
                        state_d  = S_SEND;
                        idx_d    = nxt;
                        tvalid_d = 1'b1;
                        tdata_d  = word_nxt;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (last_k[idx_q] || !found) begin
                        state_d  = S_DONE;
                        tvalid_d = 1'b0;
                    end else begin
                        idx_d   = nxt;
                        tdata_d = word_nxt;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            tvalid_q <= 1'b0;
            tdata_q  <= 16'h0000;
            prim_q   <= 2'd0;
            for (int k = 0; k < 8; k++)
                fld_q[k] <= 12'h000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            if (load) begin
                prim_q <= req_prim_i;
                fld_q  <= fld_in;
            end
        end
    end

    assign req_ready_o       = (state_q == S_IDLE);
    assign busy_o            = (state_q == S_SEND);
    assign done_o            = (state_q == S_DONE);
    assign cmd_axis_tvalid_o = tvalid_q;
    assign cmd_axis_tdata_o  = tdata_q;

endmodule
